// File: rtl/uart_pkg.sv
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART types and line-format constants (rx_fsm / tx_fsm).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  localparam int DATA_W = 8;

endpackage

`default_nettype wire

// File: rtl/rx_fsm_if.sv
// ============================================================================
// Module   : rx_fsm_if
// Brief    : Serial line input and received-word outputs of the UART receiver.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface rx_fsm_if;
  import uart_pkg::*;

  logic              RX;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;

  modport master (output RX, input data_out, data_valid, parity_err, frame_err);
  modport slave  (input RX, output data_out, data_valid, parity_err, frame_err);

endinterface

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Brief    : Two-flop synchronizer for a single asynchronous input bit.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/rx_fsm.sv
// ============================================================================
// Module   : rx_fsm
// Brief    : UART receiver: start detect, mid-bit sampling, parity/stop check.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module rx_fsm
  import uart_pkg::*;
#(
  parameter int DIVISOR     = 1000000,
  parameter int RX_NUM_BITS = 8,
  parameter int PARITY_MODE = PARITY_NONE
) (
  input  logic     clk,
  input  logic     RSTn,
  rx_fsm_if.slave  bus
);

  localparam int TMR_W = $clog2(DIVISOR);
  localparam int IDX_W = $clog2(RX_NUM_BITS + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DIVISOR - 1);
  localparam logic [TMR_W-1:0] TMR_HALF = TMR_W'(DIVISOR / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(RX_NUM_BITS - 1);

  if (DIVISOR < 4) begin : g_bad_divisor
    $error("rx_fsm: DIVISOR must be >= 4");
  end
  if (RX_NUM_BITS < 5 || RX_NUM_BITS > 8) begin : g_bad_bits
    $error("rx_fsm: RX_NUM_BITS must be in 5..8");
  end
  if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN &&
      PARITY_MODE != PARITY_ODD) begin : g_bad_parity
    $error("rx_fsm: illegal PARITY_MODE");
  end

  logic                   rx_s;
  logic                   rx_s_q, rx_s_d;
  rx_state_t              state_q, state_d;
  logic [TMR_W-1:0]       timer_q, timer_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [RX_NUM_BITS-1:0] shift_q, shift_d;
  logic                   perr_frame_q, perr_frame_d;
  logic [DATA_W-1:0]      data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   parity_err_q, parity_err_d;
  logic                   frame_err_q, frame_err_d;
  logic                   fall;

  sync_2ff #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (clk),
    .rst_n (RSTn),
    .d     (bus.RX),
    .q     (rx_s)
  );

  assign fall = rx_s_q & ~rx_s;

  always_comb begin
    rx_s_d       = rx_s;
    state_d      = state_q;
    timer_d      = timer_q + TMR_W'(1);
    idx_d        = idx_q;
    shift_d      = shift_q;
    perr_frame_d = perr_frame_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (fall) state_d = START;
      end
      START: begin
        if (timer_q == TMR_HALF) begin
          if (rx_s) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            timer_d = '0;
            idx_d   = '0;
          end
        end
      end
      DATA: begin
        // LSB arrives first, so shifting in from the top leaves it at bit 0
        if (timer_q == TMR_LAST) begin
          timer_d = '0;
          shift_d = {rx_s, shift_q[RX_NUM_BITS-1:1]};
          idx_d   = idx_q + IDX_W'(1);
          if (idx_q == IDX_LAST)
            state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (timer_q == TMR_LAST) begin
          timer_d      = '0;
          perr_frame_d = (^shift_q) ^ rx_s ^ (PARITY_MODE == PARITY_ODD);
          state_d      = STOP;
        end
      end
      STOP: begin
        if (timer_q == TMR_LAST) begin
          data_out_d                    = '0;
          data_out_d[RX_NUM_BITS-1:0]   = shift_q;
          parity_err_d = (PARITY_MODE != PARITY_NONE) && perr_frame_q;
          frame_err_d  = ~rx_s;
          data_valid_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      rx_s_q       <= 1'b1;
      state_q      <= IDLE;
      timer_q      <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      perr_frame_q <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      perr_frame_q <= perr_frame_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_rx_fsm.sv
// ============================================================================
// Module   : tb_rx_fsm
// Brief    : Directed bench for rx_fsm in 8N1, 8E1 and 5N1 configurations.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rx_fsm;
  import uart_pkg::*;

  localparam int D = 16;
  // valid arrives (1+N+P)*D + D/2 + 1 clk after the synchronized edge, +2 from the pin
  localparam int LAT_8N1 = 9 * D + D / 2 + 1 + 2;
  localparam int LAT_8E1 = 10 * D + D / 2 + 1 + 2;
  localparam int LAT_5N1 = 6 * D + D / 2 + 1 + 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rx_fsm_if if_a ();
  rx_fsm_if if_b ();
  rx_fsm_if if_c ();

  rx_fsm #(.DIVISOR(D), .RX_NUM_BITS(8), .PARITY_MODE(PARITY_NONE)) u_8n1 (
    .clk (clk), .RSTn (rst_n), .bus (if_a.slave));
  rx_fsm #(.DIVISOR(D), .RX_NUM_BITS(8), .PARITY_MODE(PARITY_EVEN)) u_8e1 (
    .clk (clk), .RSTn (rst_n), .bus (if_b.slave));
  rx_fsm #(.DIVISOR(D), .RX_NUM_BITS(5), .PARITY_MODE(PARITY_NONE)) u_5n1 (
    .clk (clk), .RSTn (rst_n), .bus (if_c.slave));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vcnt_a = 0, vcnt_b = 0, vcnt_c = 0;
  int tv_a = 0, tv_b = 0, tv_c = 0;
  always @(negedge clk) begin
    if (if_a.data_valid) begin vcnt_a <= vcnt_a + 1; tv_a <= cyc; end
    if (if_b.data_valid) begin vcnt_b <= vcnt_b + 1; tv_b <= cyc; end
    if (if_c.data_valid) begin vcnt_c <= vcnt_c + 1; tv_c <= cyc; end
  end

  int n_pass   = 0;
  int n_checks = 0;
  int t_start  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic set_rx(input int w, input logic v);
    case (w)
      0:       if_a.RX = v;
      1:       if_b.RX = v;
      default: if_c.RX = v;
    endcase
  endtask

  task automatic drive_bit(input int w, input logic v);
    set_rx(w, v);
    repeat (D) @(negedge clk);
  endtask

  // Called at a negedge; returns at a negedge with the line idle high.
  task automatic send_frame(input int w, input logic [7:0] data, input int nbits,
                            input bit has_par, input logic par_bit, input logic stop_bit);
    t_start = cyc;
    drive_bit(w, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(w, data[i]);
    if (has_par) drive_bit(w, par_bit);
    drive_bit(w, stop_bit);
    set_rx(w, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    if_a.RX = 1'b1;
    if_b.RX = 1'b1;
    if_c.RX = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data",   32'(if_a.data_out),   32'h00);
    check("rst_valid",  32'(if_a.data_valid), 32'h0);
    check("rst_perr",   32'(if_a.parity_err), 32'h0);
    check("rst_ferr",   32'(if_a.frame_err),  32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5
    send_frame(0, 8'hA5, 8, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("a5_data",    32'(if_a.data_out),   32'hA5);
    check("a5_perr",    32'(if_a.parity_err), 32'h0);
    check("a5_ferr",    32'(if_a.frame_err),  32'h0);
    check("a5_pulses",  32'(vcnt_a),          32'd1);
    check("a5_latency", 32'(tv_a - t_start),  32'(LAT_8N1));

    // 8E1: data 0x03 has even ones, so parity bit 1 is wrong
    send_frame(1, 8'h03, 8, 1'b1, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    check("e_bad_data", 32'(if_b.data_out),   32'h03);
    check("e_bad_perr", 32'(if_b.parity_err), 32'h1);
    check("e_latency",  32'(tv_b - t_start),  32'(LAT_8E1));
    send_frame(1, 8'h03, 8, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("e_ok_data",  32'(if_b.data_out),   32'h03);
    check("e_ok_perr",  32'(if_b.parity_err), 32'h0);
    check("e_pulses",   32'(vcnt_b),          32'd2);

    // Stop bit low, then a clean frame clears the flag
    send_frame(0, 8'h3C, 8, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("fe_data",    32'(if_a.data_out),   32'h3C);
    check("fe_ferr",    32'(if_a.frame_err),  32'h1);
    send_frame(0, 8'h11, 8, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("fe_clr_data", 32'(if_a.data_out),  32'h11);
    check("fe_clr_ferr", 32'(if_a.frame_err), 32'h0);
    check("fe_pulses",  32'(vcnt_a),          32'd3);

    // Short low glitch is a false start
    set_rx(0, 1'b0);
    repeat (5) @(negedge clk);
    set_rx(0, 1'b1);
    repeat (40) @(negedge clk);
    check("gl_pulses",  32'(vcnt_a),          32'd3);
    check("gl_idle",    32'(u_8n1.state_q),   32'(IDLE));
    send_frame(0, 8'h7E, 8, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("gl_data",    32'(if_a.data_out),   32'h7E);
    check("gl_latency", 32'(tv_a - t_start),  32'(LAT_8N1));
    check("gl_pulses2", 32'(vcnt_a),          32'd4);

    // 5N1, then back-to-back frames with one idle clock between
    send_frame(2, 8'h1F, 5, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("n5_data",    32'(if_c.data_out),   32'h1F);
    check("n5_latency", 32'(tv_c - t_start),  32'(LAT_5N1));
    send_frame(2, 8'h00, 5, 1'b0, 1'b0, 1'b1);
    check("b2b_data0",  32'(if_c.data_out),   32'h00);
    @(negedge clk);
    send_frame(2, 8'hFF, 5, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("b2b_data1",  32'(if_c.data_out),   32'h1F);
    check("b2b_pulses", 32'(vcnt_c),          32'd3);

    // Reset in the middle of the data bits of 0x55
    t_start = cyc;
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    repeat (D / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mr_data",    32'(if_a.data_out),   32'h00);
    check("mr_valid",   32'(if_a.data_valid), 32'h0);
    check("mr_state",   32'(u_8n1.state_q),   32'(IDLE));
    set_rx(0, 1'b1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("mr_pulses",  32'(vcnt_a),          32'd4);
    send_frame(0, 8'hAA, 8, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    check("mr_aa_data", 32'(if_a.data_out),   32'hAA);
    check("mr_aa_pulses", 32'(vcnt_a),        32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
